// File: rtl/adder33_rr_scheduler.sv
// Round-robin scheduler sharing one 33-bit + 2-bit adder between NUM_REQ requesters.
// The result lands in a single registered slot tagged with the winner's ID and is held under backpressure.
module adder33_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*33-1:0] req_a,
    input  logic [NUM_REQ*2-1:0]  req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [33:0]           rsp_sum,
    output logic [CNT_W-1:0]      op_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

    function automatic logic [33:0] add33(input logic [32:0] a, input logic [1:0] b);
        return {1'b0, a} + {32'b0, b};
    endfunction

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] x,
                                                 input logic [ID_W-1:0] y);
        logic [ID_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= (ID_W+1)'(NUM_REQ))
            s = s - (ID_W+1)'(NUM_REQ);
        return s[ID_W-1:0];
    endfunction

    slot_state_t            state;
    logic [ID_W-1:0]        ptr;
    logic [2*NUM_REQ-1:0]   dbl_vld;
    logic [NUM_REQ-1:0]     rot_vld;
    logic [ID_W-1:0]        off;
    logic                   found;
    logic [ID_W-1:0]        grant_p0;
    logic                   can_accept;
    logic                   accept_p0;
    logic [32:0]            a_p0;
    logic [1:0]             b_p0;
    logic [33:0]            sum_p0;
    logic [33:0]            sum_p1;
    logic [ID_W-1:0]        id_p1;
    logic [CNT_W-1:0]       cnt;

    // Stage p0: rotate valids so the pointer sits at bit 0, then find the first set bit
    assign dbl_vld = {req_valid, req_valid} >> ptr;
    assign rot_vld = dbl_vld[NUM_REQ-1:0];

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_vld[k]) begin
                found = 1'b1;
                off   = ID_W'(k);
            end
        end
    end

    assign grant_p0   = wrap_add(ptr, off);
    assign can_accept = (state == EMPTY) || rsp_ready;
    assign accept_p0  = can_accept && !reset && found;
    assign req_ready  = accept_p0 ? (NUM_REQ'(1) << grant_p0) : '0;

    always_comb begin
        a_p0 = '0;
        b_p0 = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_p0 == ID_W'(k)) begin
                a_p0 = req_a[33*k +: 33];
                b_p0 = req_b[2*k +: 2];
            end
        end
    end

    assign sum_p0 = add33(a_p0, b_p0);

    // Stage p1: result slot, round-robin pointer and accepted-operation counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            ptr    <= '0;
            sum_p1 <= '0;
            id_p1  <= '0;
            cnt    <= '0;
        end else if (accept_p0) begin
            state  <= FULL;
            ptr    <= wrap_add(grant_p0, ID_W'(1));
            sum_p1 <= sum_p0;
            id_p1  <= grant_p0;
            cnt    <= cnt + CNT_W'(1);
        end else if (rsp_ready) begin
            state  <= EMPTY;
        end
    end

    assign rsp_valid = (state == FULL);
    assign rsp_id    = id_p1;
    assign rsp_sum   = sum_p1;
    assign op_count  = cnt;

endmodule
